dft_wb_rr_arbiter: RTL

Two-master round-robin Wishbone arbiter that shares one Wishbone-slave DSP core (e.g. the DFT core behind its AXI4-lite bridge) between two requesters, such as the AXI4-lite bridge and a local DMA/test sequencer. It holds the grant for a whole `cyc` burst, multiplexes address, data and control to the slave, and routes responses only to the owner. A bus-timeout watchdog terminates hung transactions with an error.

---
 rtl/dft_wb_rr_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dft_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dft_wb_rr_arbiter
// Shares one Wishbone slave (the DFT core) between two Wishbone masters with
// round-robin arbitration. The grant is held for a whole cyc burst. Address,
// data and control go from the owner to the slave, and responses go back to
// the owner only. A watchdog aborts a strobed transfer that sees no ack/err
// within TIMEOUT cycles.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   m0_* / m1_*            master-side Wishbone (cyc/stb/we/adr/dat/sel in,
//                          dat/ack/err/stall out)
//   s_*                    slave-side Wishbone (cyc/stb/we/adr/dat/sel out,
//                          dat/ack/err/stall in)
//   timeout_o              one-cycle pulse when the watchdog aborts a transfer
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; slave control low, both masters stalled
// GNT0    | master 0 owns the slave until it drops cyc or times out
// GNT1    | master 1 owns the slave until it drops cyc or times out
// -----------------------------------------------------------------------------
module dft_wb_rr_arbiter #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_stall_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_stall_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_stall_i,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;       // most recent winner: 0 = m0, 1 = m1
  logic        w_last_nxt;
  logic [15:0] r_wd_cnt;
  logic        w_gnt;
  logic        w_expire;

  assign w_gnt    = (r_state != ST_IDLE);
  // Expiry needs no current stb: a nonzero count already implies the owner
  // was strobing, so an owner dropping cyc/stb right at expiry still times out.
  assign w_expire = w_gnt && (r_wd_cnt == LP_TIMEOUT) && !s_ack_i && !s_err_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Watchdog counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd_cnt <= 16'd0;
    end else if (!w_gnt || !s_stb_o || s_ack_i || s_err_i || w_expire) begin
      r_wd_cnt <= 16'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Tie: the master that did not win last time goes first.
          if (r_last) begin
            w_state_nxt = ST_GNT0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_GNT1;
            w_last_nxt  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          w_state_nxt = ST_GNT0;
          w_last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ST_GNT1;
          w_last_nxt  = 1'b1;
        end
      end
      ST_GNT0: if (!m0_cyc_i || w_expire) w_state_nxt = ST_IDLE;
      ST_GNT1: if (!m1_cyc_i || w_expire) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = m0_adr_i;
    s_dat_o    = m0_dat_i;
    s_sel_o    = m0_sel_i;
    m0_dat_o   = s_dat_i;
    m1_dat_o   = s_dat_i;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;
    timeout_o  = w_expire;
    case (r_state)
      ST_GNT0: begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i;
        s_we_o     = m0_we_i;
        m0_ack_o   = s_ack_i;
        m0_err_o   = s_err_i | w_expire;
        m0_stall_o = s_stall_i;
      end
      ST_GNT1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_sel_o    = m1_sel_i;
        m1_ack_o   = s_ack_i;
        m1_err_o   = s_err_i | w_expire;
        m1_stall_o = s_stall_i;
      end
      default: ;
    endcase
  end

endmodule
